// File: rtl/data_mem_responder.sv
// Data-memory responder: serialises one load/store at a time against an
// internal word RAM, waits WAIT_CYCLES, then pulses dmReady with
// register-ready load data or an error flag.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        dmReq,
    input  logic        dmSignal,
    input  logic [31:0] dmAddr,
    input  logic [31:0] dmStData,
    input  logic [2:0]  dmFunct3,
    output logic [31:0] dmLdData,
    output logic        dmReady,
    output logic        dmErr
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state, nextState;
    logic [3:0]  waitCnt;
    logic [31:0] reqAddr, reqStData;
    logic [2:0]  reqFunct3;
    logic        reqStore;
    logic        errReg;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      opAddr, opStData, off, rdWord, loadVal, wrData;
    logic [2:0]       opFunct3;
    logic             opStore, opErr, enterResp;
    logic [1:0]       lane;
    logic [IDX_W-1:0] wordIdx;
    logic [3:0]       byteEn;
    logic [7:0]       laneByte;
    logic [15:0]      laneHalf;

    // With zero wait cycles the accept edge is also the RESP entry edge, so the
    // live inputs are used while idle and the latched copy otherwise.
    always_comb begin
        opAddr   = (state == ST_IDLE) ? dmAddr   : reqAddr;
        opStData = (state == ST_IDLE) ? dmStData : reqStData;
        opFunct3 = (state == ST_IDLE) ? dmFunct3 : reqFunct3;
        opStore  = (state == ST_IDLE) ? dmSignal : reqStore;
        off      = opAddr - BASE_ADDR;
        lane     = opAddr[1:0];
        wordIdx  = off[IDX_W+1:2];
        opErr    = 1'b0;
        if ({1'b0, off} >= SPAN)                                  opErr = 1'b1;
        if (opFunct3 == 3'd2 && lane != 2'd0)                     opErr = 1'b1;
        if ((opFunct3 == 3'd1 || opFunct3 == 3'd5) && lane[0])    opErr = 1'b1;
        if (!opStore && (opFunct3 == 3'd3 || opFunct3[2:1] == 2'b11)) opErr = 1'b1;
        if (opStore && opFunct3 > 3'd2)                           opErr = 1'b1;
        enterResp = arstn && (((state == ST_IDLE) && dmReq && NO_WAIT) ||
                              ((state == ST_WAIT) && (waitCnt == '0)));
    end

    // Lane steering for loads (extension) and stores (byte enables, replicated data).
    always_comb begin
        rdWord = mem[wordIdx];
        case (lane)
            2'd0:    laneByte = rdWord[7:0];
            2'd1:    laneByte = rdWord[15:8];
            2'd2:    laneByte = rdWord[23:16];
            default: laneByte = rdWord[31:24];
        endcase
        laneHalf = lane[1] ? rdWord[31:16] : rdWord[15:0];
        case (opFunct3)
            3'd0:    loadVal = {{24{laneByte[7]}}, laneByte};
            3'd1:    loadVal = {{16{laneHalf[15]}}, laneHalf};
            3'd2:    loadVal = rdWord;
            3'd4:    loadVal = {24'd0, laneByte};
            3'd5:    loadVal = {16'd0, laneHalf};
            default: loadVal = '0;
        endcase
        case (opFunct3[1:0])
            2'd0: begin
                byteEn = 4'b0001 << lane;
                wrData = {4{opStData[7:0]}};
            end
            2'd1: begin
                byteEn = 4'b0011 << lane;
                wrData = {2{opStData[15:0]}};
            end
            default: begin
                byteEn = '1;
                wrData = opStData;
            end
        endcase
    end

    // Next-state decode.
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: if (dmReq) nextState = NO_WAIT ? ST_RESP : ST_WAIT;
            ST_WAIT: if (waitCnt == '0) nextState = ST_RESP;
            ST_RESP: nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    // State register, wait counter and request latch.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= ST_IDLE;
            waitCnt   <= '0;
            reqAddr   <= '0;
            reqStData <= '0;
            reqFunct3 <= '0;
            reqStore  <= 1'b0;
        end else begin
            state <= nextState;
            if (state == ST_IDLE && dmReq) begin
                reqAddr   <= dmAddr;
                reqStData <= dmStData;
                reqFunct3 <= dmFunct3;
                reqStore  <= dmSignal;
                waitCnt   <= CNT_INIT;
            end else if (state == ST_WAIT && waitCnt != '0) begin
                waitCnt <= waitCnt - 4'd1;
            end
        end
    end

    // Response registers, updated on the edge entering RESP.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            dmLdData <= '0;
            errReg   <= 1'b0;
        end else if (enterResp) begin
            errReg <= opErr;
            if (opErr)
                dmLdData <= '0;
            else if (!opStore)
                dmLdData <= loadVal;
        end
    end

    // RAM write with byte enables; contents are not reset.
    always_ff @(posedge clk) begin
        if (enterResp && opStore && !opErr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
            end
        end
    end

    assign dmReady = (state == ST_RESP);
    assign dmErr   = dmReady & errReg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: four instances at WAIT_CYCLES 1, 0, 3, 15
// driven by directed tables, randomized traffic against a reference model,
// held-request throughput and mid-operation reset sequences.
module tb_data_mem_responder;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int unsigned DEPTH = 1024;

    function automatic int unsigned wcOf(input int g);
        case (g)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        req [4];
    logic        sig [4];
    logic [31:0] addr [4];
    logic [31:0] stData [4];
    logic [2:0]  f3 [4];
    logic [31:0] ldData [4];
    logic        ready [4];
    logic        err [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gUnit
        data_mem_responder #(
            .DEPTH_WORDS(DEPTH),
            .WAIT_CYCLES(wcOf(g)),
            .BASE_ADDR(BASE)
        ) dut (
            .clk(clk),
            .arstn(arstn),
            .dmReq(req[g]),
            .dmSignal(sig[g]),
            .dmAddr(addr[g]),
            .dmStData(stData[g]),
            .dmFunct3(f3[g]),
            .dmLdData(ldData[g]),
            .dmReady(ready[g]),
            .dmErr(err[g])
        );
    end

    // Reference model: byte-addressed behaviour expressed on whole words.
    bit [31:0] mdlMem [int unsigned];
    bit [31:0] lastLd [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic bit mdlErr(input bit st, input logic [31:0] a, input logic [2:0] f);
        logic [31:0] off;
        off = a - BASE;
        if (off >= DEPTH * 4) return 1'b1;
        if (f == 3'd2 && (a % 4) != 0) return 1'b1;
        if ((f == 3'd1 || f == 3'd5) && (a % 2) != 0) return 1'b1;
        if (!st && (f == 3'd3 || f == 3'd6 || f == 3'd7)) return 1'b1;
        if (st && f > 3'd2) return 1'b1;
        return 1'b0;
    endfunction

    task automatic mdlApply(input int u, input bit st, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] f, output logic [31:0] expLd, output bit expErr);
        int unsigned key, sh;
        bit [31:0] w, b, h, mask;
        expErr = mdlErr(st, a, f);
        key = u * DEPTH + (a - BASE) / 4;
        sh = (a % 4) * 8;
        if (expErr) begin
            lastLd[u] = 0;
        end else if (st) begin
            w = mdlMem.exists(key) ? mdlMem[key] : 0;
            if (f == 3'd0) begin
                mask = 32'hFF << sh;
                w = (w & ~mask) | ((d & 32'hFF) << sh);
            end else if (f == 3'd1) begin
                mask = 32'hFFFF << sh;
                w = (w & ~mask) | ((d & 32'hFFFF) << sh);
            end else begin
                w = d;
            end
            mdlMem[key] = w;
        end else begin
            w = mdlMem[key];
            b = (w >> sh) & 32'hFF;
            h = (w >> ((a % 4) / 2 * 16)) & 32'hFFFF;
            case (f)
                3'd0:    lastLd[u] = (b >= 128) ? b - 256 : b;
                3'd1:    lastLd[u] = (h >= 32768) ? h - 65536 : h;
                3'd2:    lastLd[u] = w;
                3'd4:    lastLd[u] = b;
                default: lastLd[u] = h;
            endcase
        end
        expLd = lastLd[u];
    endtask

    // One request: checks response latency and single-cycle pulse width, and
    // scrambles the live inputs right after acceptance.
    task automatic doReq(input int u, input bit st, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, output logic [31:0] gotLd, output logic gotErr);
        int n;
        bit seen;
        @(negedge clk);
        req[u] = 1'b1; sig[u] = st; addr[u] = a; stData[u] = d; f3[u] = f;
        @(posedge clk);
        #1;
        sig[u] = ~st; addr[u] = $urandom; stData[u] = $urandom; f3[u] = 3'($urandom);
        seen = 1'b0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ready[u]) begin
                seen = 1'b1;
                break;
            end
        end
        chk($sformatf("latency u%0d", u), seen ? n : 0, wcOf(u) + 1);
        gotLd = ldData[u];
        gotErr = err[u];
        req[u] = 1'b0;
        @(negedge clk);
        chk($sformatf("pulse width u%0d", u), 32'(ready[u]), 0);
    endtask

    task automatic reqChk(input string name, input int u, input bit st, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f);
        logic [31:0] gotLd, expLd;
        logic gotErr;
        bit expErr;
        mdlApply(u, st, a, d, f, expLd, expErr);
        doReq(u, st, a, d, f, gotLd, gotErr);
        chk({name, " err"}, 32'(gotErr), 32'(expErr));
        chk({name, " data"}, gotLd, expLd);
    endtask

    typedef struct {
        bit          st;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
        logic [31:0] expLd;
        bit          expErr;
    } vec_t;
    vec_t tbl[$];

    task automatic addVec(input bit st, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f, input logic [31:0] expLd, input bit expErr);
        vec_t v;
        v.st = st; v.a = a; v.d = d; v.f = f; v.expLd = expLd; v.expErr = expErr;
        tbl.push_back(v);
    endtask

    // Hold dmReq high with loads and check pulse positions and spacing.
    task automatic heldTest(input int u);
        int pulses[$];
        int unsigned wc;
        wc = wcOf(u);
        @(negedge clk);
        req[u] = 1'b1; sig[u] = 1'b0; addr[u] = BASE; f3[u] = 3'd2;
        for (int k = 0; k < int'(4 * wc + 8); k++) begin
            @(negedge clk);
            if (ready[u]) pulses.push_back(k);
        end
        req[u] = 1'b0;
        repeat (3) @(negedge clk);
        lastLd[u] = mdlMem[u * DEPTH];
        chk($sformatf("held pulse count u%0d", u), pulses.size(), 4);
        if (pulses.size() == 4) begin
            chk($sformatf("held first pulse u%0d", u), pulses[0], wc);
            for (int i = 1; i < 4; i++)
                chk($sformatf("held spacing u%0d", u), pulses[i] - pulses[i-1], wc + 2);
        end
    endtask

    initial begin
        logic [31:0] gotLd, expLd, a;
        logic gotErr;
        bit expErr, st;
        logic [2:0] f;
        int r, highs;

        for (int u = 0; u < 4; u++) begin
            req[u] = 1'b0; sig[u] = 1'b0; addr[u] = '0; stData[u] = '0; f3[u] = '0;
            lastLd[u] = 0;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            chk($sformatf("reset ready u%0d", u), 32'(ready[u]), 0);
            chk($sformatf("reset err u%0d", u), 32'(err[u]), 0);
            chk($sformatf("reset data u%0d", u), ldData[u], 0);
        end
        arstn = 1'b1;

        // Directed table on the WAIT_CYCLES=1 instance.
        addVec(1, 32'h0001_0004, 32'hDEAD_BEEF, 3'd2, 32'h0000_0000, 0);
        addVec(0, 32'h0001_0004, 32'h0,         3'd2, 32'hDEAD_BEEF, 0);
        addVec(1, 32'h0001_0008, 32'h0,         3'd2, 32'hDEAD_BEEF, 0);
        addVec(1, 32'h0001_000A, 32'h80,        3'd0, 32'hDEAD_BEEF, 0);
        addVec(1, 32'h0001_0008, 32'hFFFE,      3'd1, 32'hDEAD_BEEF, 0);
        addVec(0, 32'h0001_0008, 32'h0,         3'd2, 32'h0080_FFFE, 0);
        addVec(0, 32'h0001_000A, 32'h0,         3'd0, 32'hFFFF_FF80, 0);
        addVec(0, 32'h0001_000A, 32'h0,         3'd4, 32'h0000_0080, 0);
        addVec(0, 32'h0001_0008, 32'h0,         3'd1, 32'hFFFF_FFFE, 0);
        addVec(0, 32'h0001_0008, 32'h0,         3'd5, 32'h0000_FFFE, 0);
        addVec(0, 32'h0001_0002, 32'h0,         3'd2, 32'h0000_0000, 1);
        addVec(1, 32'h0001_0000, 32'h5566_7788, 3'd2, 32'h0000_0000, 0);
        addVec(1, 32'h0001_0001, 32'hBEEF,      3'd1, 32'h0000_0000, 1);
        addVec(0, 32'h0001_0000, 32'h0,         3'd2, 32'h5566_7788, 0);
        addVec(0, 32'h0000_FFFC, 32'h0,         3'd2, 32'h0000_0000, 1);
        addVec(0, 32'h0001_1000, 32'h0,         3'd2, 32'h0000_0000, 1);
        addVec(0, 32'h0001_0000, 32'h0,         3'd3, 32'h0000_0000, 1);
        addVec(1, 32'h0001_0000, 32'h1111_1111, 3'd3, 32'h0000_0000, 1);
        addVec(0, 32'h0001_0000, 32'h0,         3'd2, 32'h5566_7788, 0);
        addVec(1, 32'h0001_0FFC, 32'hCAFE_F00D, 3'd2, 32'h5566_7788, 0);
        addVec(0, 32'h0001_0FFC, 32'h0,         3'd2, 32'hCAFE_F00D, 0);
        addVec(0, 32'h0001_000A, 32'h0,         3'd1, 32'h0000_0080, 0);
        addVec(0, 32'h0001_000B, 32'h0,         3'd0, 32'h0000_0000, 0);
        addVec(0, 32'h0001_0009, 32'h0,         3'd4, 32'h0000_00FF, 0);
        addVec(0, 32'h0001_0009, 32'h0,         3'd0, 32'hFFFF_FFFF, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            mdlApply(0, tbl[i].st, tbl[i].a, tbl[i].d, tbl[i].f, expLd, expErr);
            doReq(0, tbl[i].st, tbl[i].a, tbl[i].d, tbl[i].f, gotLd, gotErr);
            chk($sformatf("vec%0d err", i), 32'(gotErr), 32'(tbl[i].expErr));
            chk($sformatf("vec%0d data", i), gotLd, tbl[i].expLd);
        end

        // Randomized traffic on an initialised window plus out-of-range probes.
        for (int w = 0; w < 8; w++)
            reqChk("rnd init", 0, 1'b1, 32'h0001_0100 + 32'(w * 4), $urandom, 3'd2);
        for (int i = 0; i < 150; i++) begin
            st = 1'($urandom);
            f = 3'($urandom);
            r = int'($urandom_range(15, 0));
            if (r == 0)      a = BASE + DEPTH * 4 + $urandom_range(63, 0);
            else if (r == 1) a = BASE - 1 - $urandom_range(63, 0);
            else             a = 32'h0001_0100 + $urandom_range(31, 0);
            reqChk($sformatf("rnd%0d", i), 0, st, a, $urandom, f);
        end

        // Latency sweep and held-request throughput on every instance.
        for (int u = 0; u < 4; u++) begin
            reqChk($sformatf("sweep sw u%0d", u), u, 1'b1, BASE, 32'hA5A5_0000 | 32'(u), 3'd2);
            reqChk($sformatf("sweep lw u%0d", u), u, 1'b0, BASE, 32'h0, 3'd2);
            heldTest(u);
        end

        // Mid-operation reset on the WAIT_CYCLES=3 instance.
        reqChk("midrst pre", 2, 1'b1, 32'h0001_0010, 32'hAAAA_AAAA, 3'd2);
        @(negedge clk);
        req[2] = 1'b1; sig[2] = 1'b1; addr[2] = 32'h0001_0010; stData[2] = 32'h1234_5678; f3[2] = 3'd2;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        arstn = 1'b0;
        req[2] = 1'b0;
        #1;
        chk("midrst ready", 32'(ready[2]), 0);
        chk("midrst data", ldData[2], 0);
        @(posedge clk);
        #1;
        arstn = 1'b1;
        for (int u = 0; u < 4; u++) lastLd[u] = 0;
        highs = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready[2]) highs++;
        end
        chk("midrst no response", highs, 0);
        reqChk("midrst lw", 2, 1'b0, 32'h0001_0010, 32'h0, 3'd2);
        chk("midrst preserved", lastLd[2], 32'hAAAA_AAAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder side of the core's data-memory port. Accepts one load or store request at a time from the pipeline MEM stage and services it against an internal word-organised RAM. Waits a fixed, configurable number of cycles, then returns a one-cycle ready pulse with load data or an error flag. Handles RV32 byte, halfword and word accesses, including lane steering and sign/zero extension, so the core sees register-ready load data.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM; power of two, at least 4.
WAIT_CYCLES, 1, extra wait cycles between request accept and response; 0 to 15.
BASE_ADDR, 32'h0001_0000, byte address of word 0; must be 4-byte aligned.

Ports:
clk  input  1  system clock, rising edge
arstn  input  1  asynchronous active-low reset
dmReq  input  1  request valid; held high by the requester until it samples dmReady
dmSignal  input  1  1 = store, 0 = load
dmAddr  input  32  byte address
dmStData  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
dmFunct3  input  3  RV32 funct3 of the load/store (size and signedness)
dmLdData  output  32  load result, extended to 32 bits
dmReady  output  1  one-cycle response pulse
dmErr  output  1  error flag, valid only while dmReady=1

Behaviour:
- Reset (arstn=0, asynchronous):
  - FSM goes to IDLE; wait counter clears.
  - dmReady=0, dmErr=0, dmLdData=32'h0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on a rising edge with dmReq=1, latch dmAddr, dmStData, dmFunct3 and dmSignal (the accept edge).
    - Go to WAIT with counter = WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise go straight to RESP.
  - WAIT: decrement the counter each cycle. When the counter is 0, go to RESP.
  - RESP: dmReady=1 for exactly this one cycle, then go to IDLE. dmReq is ignored while in WAIT or RESP.
- Timing:
  - dmReady is high in the (WAIT_CYCLES+1)-th cycle after the accept edge.
  - The next request can be accepted no earlier than the edge ending the first IDLE cycle after RESP. Peak throughput is therefore one request per WAIT_CYCLES+2 cycles.
  - The requester deasserts dmReq in the cycle after it samples dmReady.
- Error check, evaluated on the latched request; any one of these sets the error:
  - Offset out of range: off = addr - BASE_ADDR (unsigned 32-bit) with off >= DEPTH_WORDS*4. An address below BASE_ADDR wraps to a large offset and therefore errors.
  - Misaligned word access: funct3 = 2 with addr[1:0] != 0.
  - Misaligned halfword access: funct3 in {1,5} with addr[0] != 0.
  - Illegal funct3 for a load: 3, 6 or 7.
  - Illegal funct3 for a store: greater than 2.
- On error: dmErr=1 with dmReady, dmLdData=0, and no RAM write.
- Word index = off[log2(DEPTH_WORDS)+1:2]; lane = addr[1:0].
- Stores (no error):
  - SB writes dmStData[7:0] into byte lane `lane` only.
  - SH writes dmStData[15:0] into bytes lane and lane+1 only.
  - SW writes all four bytes.
  - The write occurs on the edge entering RESP. Unwritten bytes are preserved.
  - dmLdData holds its previous value; dmErr=0.
- Loads (no error):
  - The RAM is read on the edge entering RESP.
  - Selected byte or half is right-aligned: LB/LH sign-extend, LBU/LHU zero-extend, LW returns the full word.
  - dmLdData is registered and holds its value until the next load response, error, or reset.
- Read-after-write: a load accepted after a store's RESP cycle returns the stored data (no bypass needed; requests are serialised).
- Reset mid-operation:
  - Reset asserted before the edge entering RESP: the request is abandoned, no write occurs, and no response is produced.
  - After reset release, the block is in IDLE; a dmReq still high is accepted as a new request.
- Simultaneous events: a dmReq change during WAIT or RESP has no effect. Latched operands are used, not live inputs.

Test Plan:
- Reset with WAIT_CYCLES=1: hold arstn=0 -> dmReady=0, dmErr=0, dmLdData=0. Release, SW 0xDEADBEEF @0x00010004, then LW @0x00010004 -> each dmReady pulses exactly 2 cycles after accept; LW returns 0xDEADBEEF with dmErr=0.
- Byte/half lanes: SW 0x00000000 @0x00010008, SB 0x80 @0x0001000A, SH 0xFFFE @0x00010008 ->
  - LW = 0x0080FFFE
  - LB @0x0001000A = 0xFFFFFF80
  - LBU @0x0001000A = 0x00000080
  - LH @0x00010008 = 0xFFFFFFFE
  - LHU @0x00010008 = 0x0000FFFE
- Errors:
  - LW @0x00010002 -> dmErr=1, dmLdData=0.
  - SH @0x00010001 -> dmErr=1; the target word is unchanged.
  - LW @0x0000FFFC -> dmErr=1.
  - LW @BASE_ADDR+DEPTH_WORDS*4 -> dmErr=1.
  - Load funct3=3 -> dmErr=1.
- Latency sweep WAIT_CYCLES = 0, 3, 15 -> dmReady is a single-cycle pulse at accept+1, accept+4 and accept+16. Back-to-back held requests are spaced exactly WAIT_CYCLES+2 cycles apart.
- Mid-op reset: SW 0x12345678 @0x00010010 over prior contents 0xAAAAAAAA, WAIT_CYCLES=3; pulse arstn low 2 cycles after accept -> no dmReady. A subsequent LW @0x00010010 returns 0xAAAAAAAA.
- Input stability: change dmAddr and dmStData during WAIT -> the response and write use the values latched at the accept edge.
